// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 8;
    localparam int ACC_W      = NUM_DIGITS * 4;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector: adds 3 to a nibble of 5 or more
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble converter, one input bit per clock
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done,
    output logic [15:0]      bcd_l,
    output logic [15:0]      bcd_h
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_fix;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        bcd_l_q, bcd_l_d;
    logic [15:0]        bcd_h_q, bcd_h_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_fix[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_l_d = bcd_l_q;
        bcd_h_d = bcd_h_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_CONVERT;
                    ready_d = 1'b0;
                end
            end
            ST_CONVERT: begin
                // Correct first, then shift the next binary MSB into digit 0.
                acc_d   = (acc_fix << 1) | ACC_W'(shift_q[BIN_W-1]);
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_l_d = acc_q[15:0];
                bcd_h_d = acc_q[31:16];
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_l_q <= '0;
            bcd_h_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_l_q <= bcd_l_d;
            bcd_h_q <= bcd_h_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign bcd_l = bcd_l_q;
    assign bcd_h = bcd_h_q;

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16, binary input width, legal range 1..26 (result always fits 8 BCD digits).
REQ-002 The block SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  conversion request, sampled on rising clk.
REQ-005 The block SHALL have port bin  input  BIN_W  unsigned binary value, sampled when start is accepted.
REQ-006 The block SHALL have port ready  output  1  high only in IDLE; start is accepted only when ready=1.
REQ-007 The block SHALL have port done  output  1  single-cycle pulse marking a new result.
REQ-008 The block SHALL have port bcd_l  output  16  digits 3..0, nibble 0 = units; drives the display's low-nibble input.
REQ-009 The block SHALL have port bcd_h  output  16  digits 7..4; drives the display's high-nibble input.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, CONVERT, DONE.
REQ-011 In IDLE with start=1 at edge N, the block SHALL latch bin into a shift register, clear the 32-bit BCD accumulator, load bit counter with BIN_W, and enter CONVERT.
REQ-012 In CONVERT, each edge SHALL apply add-3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit (MSB of bin enters accumulator bit 0), and decrement the counter.
REQ-013 CONVERT SHALL last exactly BIN_W edges, then move to DONE.
REQ-014 At edge N+BIN_W+1, bcd_l/bcd_h SHALL load the final accumulator and done SHALL rise, staying high exactly one clock (DONE state), then FSM returns to IDLE.
REQ-015 Latency SHALL be BIN_W+1 clocks from accepting start to done; minimum start-to-start spacing SHALL be BIN_W+2 clocks.
REQ-016 bcd_l/bcd_h SHALL hold their value between completions; intermediate accumulator values SHALL never appear on them.
REQ-017 start while ready=0 (CONVERT or DONE) SHALL be ignored with no queueing; bin changes during CONVERT SHALL not affect the result.
REQ-018 start held high continuously SHALL yield back-to-back conversions, one every BIN_W+2 clocks.
REQ-019 Unused upper digits SHALL be 0 (e.g. BIN_W=16 → bcd_h[15:4] always 0).
REQ-020 Every output nibble SHALL be a legal BCD digit 0..9.

Reset
REQ-021 reset=1 SHALL asynchronously force FSM to IDLE, ready=1, done=0, bcd_l=16'h0000, bcd_h=16'h0000, counter and internal registers to 0.
REQ-022 reset asserted mid-CONVERT SHALL abort the conversion with no done pulse; the first start after release SHALL be handled normally.
REQ-023 On reset deassertion, the first edge SHALL already be able to accept start.

Structure
REQ-024 Package bin_to_bcd_pkg SHALL hold the FSM state enumeration and constant NUM_DIGITS=8.
REQ-025 The per-digit add-3 corrector SHALL be a sub-module bcd_add3 (4-bit in, 4-bit out, combinational), instantiated NUM_DIGITS times.
REQ-026 All state SHALL be in a single clk domain; no latches.

Verification
REQ-027 BIN_W=16, bin=0, start pulse → done after 17 clocks; bcd_h=16'h0000, bcd_l=16'h0000.
REQ-028 BIN_W=16, bin=65535 → bcd_h=16'h0006, bcd_l=16'h5535 at done; bin=9999 → bcd_l=16'h9999, bcd_h=0.
REQ-029 BIN_W=26, bin=67108863 → bcd_h=16'h6710, bcd_l=16'h8863 after 27 clocks.
REQ-030 Start bin=1234; re-pulse start with bin=4321 at clock 5 → ignored; single done, bcd_l=16'h1234.
REQ-031 Reset asserted at clock 8 of conversion → outputs 0, ready=1 immediately, no done; next start bin=42 → bcd_l=16'h0042.
REQ-032 start held high, bins 100 then 200 → done pulses exactly 18 clocks apart, results 16'h0100 then 16'h0200.
